// File: rtl/vq_lbg_pkg.sv
// Shared state encoding, codebook-mux codes and per-state select decode for the LBG trainer.
package vq_lbg_pkg;

  localparam int DIST_W_DFLT = 41;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEAN  = 3'd1,
    ST_SPLIT = 3'd2,
    ST_CLS   = 3'd3,
    ST_UPD   = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic [1:0] CB_SEL_MEAN  = 2'd0;
  localparam logic [1:0] CB_SEL_SPLIT = 2'd1;
  localparam logic [1:0] CB_SEL_UPD   = 2'd2;
  localparam logic [1:0] CB_SEL_NONE  = 2'd3;

  function automatic logic [1:0] cb_sel_of(input state_e s);
    logic [1:0] sel;
    case (s)
      ST_MEAN:  sel = CB_SEL_MEAN;
      ST_SPLIT: sel = CB_SEL_SPLIT;
      ST_UPD:   sel = CB_SEL_UPD;
      default:  sel = CB_SEL_NONE;
    endcase
    return sel;
  endfunction

  // MFCC port belongs to the mean engine only while it runs; idle parks it at 0 as well.
  function automatic logic mfcc_sel_of(input state_e s);
    return (s != ST_IDLE) && (s != ST_MEAN);
  endfunction

endpackage

// File: rtl/vq_lbg_conv_chk.sv
// Combinational convergence test: relative distortion drop below 2^-THR_SHIFT, or zero distortion.
module vq_lbg_conv_chk #(
  parameter int DIST_W    = 41,
  parameter int THR_SHIFT = 6
) (
  input  logic [DIST_W-1:0] d_prev,
  input  logic [DIST_W-1:0] d_cur,
  output logic              conv
);

  localparam int EXT_W = DIST_W + THR_SHIFT;

  logic [DIST_W-1:0] diff;
  logic [EXT_W-1:0]  diff_sh;
  logic [EXT_W-1:0]  cur_ext;
  logic              non_div;

  // Widened so the shifted drop can never wrap past D_cur.
  always_comb begin
    diff    = d_prev - d_cur;
    diff_sh = EXT_W'(diff) << THR_SHIFT;
    cur_ext = EXT_W'(d_cur);
    non_div = (d_prev >= d_cur);
    conv    = (d_cur == '0) || (non_div && (diff_sh < cur_ext));
  end

endmodule

// File: rtl/vq_lbg_train_ctrl.sv
// LBG codebook-training sequencer: mean-init, then per level split -> (classify -> check -> update)*.
// Engine starts are 1-cycle registered pulses on state entry; abort returns to IDLE on the next edge.
module vq_lbg_train_ctrl
  import vq_lbg_pkg::*;
#(
  parameter int LOG2_K    = 4,
  parameter int MAX_ITER  = 8,
  parameter int THR_SHIFT = 6,
  parameter int DIST_W    = DIST_W_DFLT,
  parameter int FRAME_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] frame_num,
  output logic               busy,
  output logic               done,
  output logic               err_nodata,
  output logic [2:0]         level,
  output logic [7:0]         iter_cnt,
  output logic [DIST_W-1:0]  final_dist,
  output logic               empty_cells,
  output logic               mean_start,
  input  logic               mean_done,
  output logic               split_start,
  input  logic               split_done,
  output logic               cls_start,
  input  logic               cls_done,
  input  logic [DIST_W-1:0]  cls_dist,
  output logic               upd_start,
  input  logic               upd_done,
  input  logic               upd_empty,
  output logic [1:0]         cb_wr_sel,
  output logic               mfcc_rd_sel
);

  state_e            state_q, state_d;
  logic [2:0]        level_q, level_d;
  logic [7:0]        iter_q, iter_d;
  logic [7:0]        iter_inc;
  logic [DIST_W-1:0] d_prev_q, d_prev_d;
  logic [DIST_W-1:0] d_cur_q, d_cur_d;
  logic [DIST_W-1:0] final_q, final_d;
  logic              empty_q, empty_d;
  logic              mean_go, split_go, cls_go, upd_go, done_go, nodata_go;
  logic              conv;

  vq_lbg_conv_chk #(
    .DIST_W    (DIST_W),
    .THR_SHIFT (THR_SHIFT)
  ) u_conv_chk (
    .d_prev (d_prev_q),
    .d_cur  (d_cur_q),
    .conv   (conv)
  );

  assign iter_inc = iter_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    iter_d    = iter_q;
    d_prev_d  = d_prev_q;
    d_cur_d   = d_cur_q;
    final_d   = final_q;
    empty_d   = empty_q;
    mean_go   = 1'b0;
    split_go  = 1'b0;
    cls_go    = 1'b0;
    upd_go    = 1'b0;
    done_go   = 1'b0;
    nodata_go = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (frame_num == '0) begin
              nodata_go = 1'b1;
            end else begin
              state_d = ST_MEAN;
              mean_go = 1'b1;
              level_d = '0;
              iter_d  = '0;
              empty_d = 1'b0;
              final_d = '0;
            end
          end
        end
        ST_MEAN: begin
          if (mean_done) begin
            state_d  = ST_SPLIT;
            split_go = 1'b1;
          end
        end
        ST_SPLIT: begin
          if (split_done) begin
            state_d  = ST_CLS;
            cls_go   = 1'b1;
            level_d  = level_q + 3'd1;
            iter_d   = '0;
            d_prev_d = '1;
          end
        end
        ST_CLS: begin
          if (cls_done) begin
            d_cur_d = cls_dist;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          iter_d = iter_inc;
          if (conv || (iter_inc == 8'(MAX_ITER))) begin
            if (level_q == 3'(LOG2_K)) begin
              state_d = ST_DONE;
              done_go = 1'b1;
              final_d = d_cur_q;
            end else begin
              state_d  = ST_SPLIT;
              split_go = 1'b1;
            end
          end else begin
            d_prev_d = d_cur_q;
            state_d  = ST_UPD;
            upd_go   = 1'b1;
          end
        end
        ST_UPD: begin
          if (upd_done) begin
            state_d = ST_CLS;
            cls_go  = 1'b1;
            empty_d = empty_q | upd_empty;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      iter_q      <= '0;
      d_prev_q    <= '1;
      d_cur_q     <= '0;
      final_q     <= '0;
      empty_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_nodata  <= 1'b0;
      mean_start  <= 1'b0;
      split_start <= 1'b0;
      cls_start   <= 1'b0;
      upd_start   <= 1'b0;
      cb_wr_sel   <= CB_SEL_NONE;
      mfcc_rd_sel <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      iter_q      <= iter_d;
      d_prev_q    <= d_prev_d;
      d_cur_q     <= d_cur_d;
      final_q     <= final_d;
      empty_q     <= empty_d;
      busy        <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done        <= done_go;
      err_nodata  <= nodata_go;
      mean_start  <= mean_go;
      split_start <= split_go;
      cls_start   <= cls_go;
      upd_start   <= upd_go;
      cb_wr_sel   <= cb_sel_of(state_d);
      mfcc_rd_sel <= mfcc_sel_of(state_d);
    end
  end

  assign level       = level_q;
  assign iter_cnt    = iter_q;
  assign final_dist  = final_q;
  assign empty_cells = empty_q;

endmodule

// File: tb/tb_vq_lbg_train_ctrl.sv
// Bench for vq_lbg_train_ctrl (LOG2_K=2): inline engine models with 2-cycle latency, done scoreboard.
module tb_vq_lbg_train_ctrl;

  localparam int LOG2_K = 2;
  localparam int DW     = 41;
  localparam int FW     = 9;
  localparam int LAT    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [FW-1:0] frame_num;
  logic          busy, done, err_nodata;
  logic [2:0]    level;
  logic [7:0]    iter_cnt;
  logic [DW-1:0] final_dist;
  logic          empty_cells;
  logic          mean_start, mean_done, split_start, split_done;
  logic          cls_start, cls_done, upd_start, upd_done, upd_empty;
  logic [DW-1:0] cls_dist;
  logic [1:0]    cb_wr_sel;
  logic          mfcc_rd_sel;

  typedef struct {
    logic [DW-1:0] fin;
    logic [7:0]    iter;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] cb_trace[$];
  logic [1:0] cb_last;
  int n_vec = 0, n_err = 0;
  int n_mean = 0, n_split = 0, n_cls = 0, n_upd = 0, n_done = 0;
  int mean_cd = 0, split_cd = 0, cls_cd = 0, upd_cd = 0;
  int pass_lvl = 0, mode = 0, empty_at = -1;

  always #5 clk = ~clk;

  vq_lbg_train_ctrl #(
    .LOG2_K(LOG2_K), .MAX_ITER(8), .THR_SHIFT(6), .DIST_W(DW), .FRAME_W(FW)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_num(frame_num),
    .busy(busy), .done(done), .err_nodata(err_nodata), .level(level),
    .iter_cnt(iter_cnt), .final_dist(final_dist), .empty_cells(empty_cells),
    .mean_start(mean_start), .mean_done(mean_done),
    .split_start(split_start), .split_done(split_done),
    .cls_start(cls_start), .cls_done(cls_done), .cls_dist(cls_dist),
    .upd_start(upd_start), .upd_done(upd_done), .upd_empty(upd_empty),
    .cb_wr_sel(cb_wr_sel), .mfcc_rd_sel(mfcc_rd_sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Classifier distortion per pass within a level, by scenario.
  function automatic logic [DW-1:0] dist_of(input int m, input int p);
    logic [DW-1:0] d;
    case (m)
      0:       d = (p == 0) ? DW'(1000) : DW'(999);
      1:       d = DW'(32'd1000 >> p);
      2:       d = DW'(1000 + 100 * p);
      default: d = '0;
    endcase
    return d;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    mean_done = 1'b0; split_done = 1'b0; cls_done = 1'b0; upd_done = 1'b0; upd_empty = 1'b0;
    if (mean_cd > 0) begin mean_cd--; if (mean_cd == 0) mean_done = 1'b1; end
    if (split_cd > 0) begin split_cd--; if (split_cd == 0) split_done = 1'b1; end
    if (cls_cd > 0) begin
      cls_cd--;
      if (cls_cd == 0) begin cls_done = 1'b1; cls_dist = dist_of(mode, pass_lvl); pass_lvl++; end
    end
    if (upd_cd > 0) begin
      upd_cd--;
      if (upd_cd == 0) begin upd_done = 1'b1; upd_empty = (n_upd == empty_at); end
    end
    if (mean_start)  begin n_mean++;  mean_cd = LAT; end
    if (split_start) begin n_split++; split_cd = LAT; pass_lvl = 0; end
    if (cls_start)   begin n_cls++;   cls_cd = LAT; end
    if (upd_start)   begin n_upd++;   upd_cd = LAT; end
    if (cb_wr_sel != cb_last) begin cb_trace.push_back(cb_wr_sel); cb_last = cb_wr_sel; end
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("done_unexpected", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("final_dist", 64'(final_dist), 64'(e.fin));
        chk("iter_at_done", 64'(iter_cnt), 64'(e.iter));
        chk("level_at_done", 64'(level), 64'(LOG2_K));
      end
    end
  endtask

  task automatic run_case(input string tag, input int m, input logic [DW-1:0] efin,
                          input int eiter, input int ecls, input int eupd);
    int b_mean, b_split, b_cls, b_upd, b_done;
    b_mean = n_mean; b_split = n_split; b_cls = n_cls; b_upd = n_upd; b_done = n_done;
    mode = m;
    cb_trace.delete();
    cb_last = cb_wr_sel;
    sb.push_back('{efin, 8'(eiter)});
    frame_num = 9'd20; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_entry_busy"}, 64'(busy), 64'(1));
    chk({tag, "_entry_mean"}, 64'(mean_start), 64'(1));
    chk({tag, "_entry_sel"}, 64'({cb_wr_sel, mfcc_rd_sel}), 64'({2'd0, 1'b0}));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && n_done == b_done; i++) tick();
    chk({tag, "_done_seen"}, 64'(n_done - b_done), 64'(1));
    tick();
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    chk({tag, "_n_mean"}, 64'(n_mean - b_mean), 64'(1));
    chk({tag, "_n_split"}, 64'(n_split - b_split), 64'(LOG2_K));
    chk({tag, "_n_cls"}, 64'(n_cls - b_cls), 64'(ecls));
    chk({tag, "_n_upd"}, 64'(n_upd - b_upd), 64'(eupd));
  endtask

  initial begin
    logic [1:0] cb_exp [9];
    int b_cls, b_done, b_mean, n_tr;
    bit hit;
    cb_exp = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};
    rst = 1'b1; start = 1'b0; abort = 1'b0; frame_num = '0;
    mean_done = 1'b0; split_done = 1'b0; cls_done = 1'b0; upd_done = 1'b0;
    upd_empty = 1'b0; cls_dist = '0; cb_last = 2'd3;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cb_sel", 64'(cb_wr_sel), 64'(3));
    chk("rst_mfcc_sel", 64'(mfcc_rd_sel), 64'(0));
    chk("rst_level_iter", 64'({level, iter_cnt}), 64'(0));
    chk("rst_final_empty", 64'({final_dist, empty_cells}), 64'(0));
    chk("rst_starts", 64'({mean_start, split_start, cls_start, upd_start, err_nodata}), 64'(0));

    // No frames: error pulse only.
    b_mean = n_mean;
    frame_num = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nodata_err", 64'(err_nodata), 64'(1));
    chk("nodata_busy", 64'(busy), 64'(0));
    tick();
    chk("nodata_err_clear", 64'(err_nodata), 64'(0));
    chk("nodata_no_mean", 64'(n_mean - b_mean), 64'(0));

    // Converges on pass 2 every level; first update reports an empty cell.
    empty_at = n_upd + 1;
    run_case("conv", 0, DW'(999), 2, 4, 2);
    n_tr = cb_trace.size();
    chk("cb_trace_len", 64'(n_tr), 64'(9));
    for (int i = 0; i < 9 && i < n_tr; i++) chk("cb_trace", 64'(cb_trace[i]), 64'(cb_exp[i]));
    chk("empty_sticky", 64'(empty_cells), 64'(1));
    chk("final_held", 64'(final_dist), 64'(999));
    empty_at = -1;

    // Halving distortion never converges: forced advance after 8 passes.
    frame_num = 9'd20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_cleared", 64'(empty_cells), 64'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    run_case("halve", 1, DW'(7), 8, 16, 14);
    run_case("diverge", 2, DW'(1700), 8, 16, 14);
    run_case("zero", 3, DW'(0), 1, 2, 0);

    // Abort on UPD entry; the in-flight upd_done must not restart classification.
    mode = 0;
    b_done = n_done;
    frame_num = 9'd20; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick();
      hit = upd_start;
    end
    chk("abort_upd_reached", 64'(hit), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_cb_sel", 64'(cb_wr_sel), 64'(3));
    b_cls = n_cls;
    for (int i = 0; i < 8; i++) tick();
    chk("abort_no_cls", 64'(n_cls - b_cls), 64'(0));
    chk("abort_no_done", 64'(n_done - b_done), 64'(0));
    chk("abort_idle_busy", 64'(busy), 64'(0));

    run_case("recover", 3, DW'(0), 1, 2, 0);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
